// File: rtl/rv_wb_pkg.sv
// Purpose: shared types for Wishbone classic slaves (handshake states, captured request).
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package rv_wb_pkg;

  // Handshake states shared by the single-outstanding Wishbone slaves.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_t;

  // Request fields latched at capture; the word address is kept separately
  // because its width depends on the slave's depth.
  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

  // Width of a down-counter that has to hold the value ws; never narrower than 1 bit.
  function automatic int cnt_width(input int ws);
    return (ws < 1) ? 1 : $clog2(ws + 1);
  endfunction

endpackage

// File: rtl/rv_sram_bytes.sv
// Purpose: synchronous single-port 32-bit RAM with per-byte write enables and an INIT_FILE parameter.
// Latency: read data registered on the access edge; writes land on the same edge.
// Backpressure: none; one access per enabled cycle.
// Ports: i_clk, i_rst (async, clears only the read register), i_en access strobe, i_we write,
//        i_be byte enables, i_addr word address, i_wdat write data, o_rdat held read data.
module rv_sram_bytes #(
  parameter int    ADDR_BITS = 14,
  parameter string INIT_FILE = ""
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [3:0]           i_be,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [31:0]          i_wdat,
  output logic [31:0]          o_rdat
);

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  // The array has no reset so its contents survive a reset of the bus logic.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          mem[i_addr][8*b +: 8] <= i_wdat[8*b +: 8];
        end
      end
    end
  end

  // Read register only moves on a read, so it holds the last read word across writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdat <= '0;
    end else if (i_en && !i_we) begin
      o_rdat <= mem[i_addr];
    end
  end

endmodule

// File: rtl/rv_wb_sram.sv
// Purpose: Wishbone classic slave in front of a byte-writable single-port SRAM.
// Latency: request-to-ack WAIT_STATES+1 cycles; one access per WAIT_STATES+2 cycles.
// Backpressure: one request outstanding; stb ignored outside IDLE; cyc low in WAIT aborts.
// Ports: i_clk, i_reset (async active-high); i_wb_adr byte address, i_wb_dat write data,
//        i_wb_we, i_wb_sel byte enables, i_wb_stb, i_wb_cyc; o_wb_dat read data, o_wb_ack.
module rv_wb_sram
  import rv_wb_pkg::*;
#(
  parameter int    ADDR_BITS   = 14,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_stb,
  input  logic        i_wb_cyc,
  output logic        o_wb_ack
);

  localparam int            CW    = cnt_width(WAIT_STATES);
  localparam logic [CW-1:0] WS_LD = CW'(WAIT_STATES);

  wb_state_t             state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  capture;
  logic                  acc_en;
  logic [ADDR_BITS-1:0]  word_adr;
  logic [ADDR_BITS-1:0]  cap_adr;
  logic [ADDR_BITS-1:0]  acc_adr;
  wb_req_t               live_req;
  wb_req_t               cap_req;
  wb_req_t               acc_req;
  logic                  unused_adr_bits;

  // Byte-lane bits and everything above the array depth do not decode, so
  // upper addresses alias onto the same words.
  assign word_adr        = i_wb_adr[ADDR_BITS+1:2];
  assign unused_adr_bits = ^{i_wb_adr[1:0], i_wb_adr[31:ADDR_BITS+2]};

  assign live_req.dat = i_wb_dat;
  assign live_req.sel = i_wb_sel;
  assign live_req.we  = i_wb_we;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt = ACK;
            acc_en    = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WS_LD;
          end
        end
      end
      WAIT: begin
        // An abort wins even on the last wait cycle: nothing is committed yet.
        if (!i_wb_cyc) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(1)) begin
          state_nxt = ACK;
          cnt_nxt   = '0;
          acc_en    = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ACK: begin
        // Unconditional return; a held-high stb is only seen again from IDLE.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cap_adr <= '0;
      cap_req <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        cap_adr <= word_adr;
        cap_req <= live_req;
      end
    end
  end

  // Accesses normally come from the captured request; only the zero-wait path
  // reaches memory on the capture edge itself, where live and captured agree.
  assign acc_adr = (state == IDLE) ? word_adr : cap_adr;
  assign acc_req = (state == IDLE) ? live_req : cap_req;

  assign o_wb_ack = (state == ACK);

  rv_sram_bytes #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk  (i_clk),
    .i_rst  (i_reset),
    .i_en   (acc_en & ~i_reset),
    .i_we   (acc_req.we),
    .i_be   (acc_req.sel),
    .i_addr (acc_adr),
    .i_wdat (acc_req.dat),
    .o_rdat (o_wb_dat)
  );

endmodule

// File: tb/tb_rv_wb_sram.sv
`timescale 1ns/1ps
// Purpose: bench for rv_wb_sram; two instances (1 and 2 wait states) share one bus driver.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv_wb_sram;

  localparam int AB    = 6;
  localparam int DEPTH = 1 << AB;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      adr = '0;
  logic [31:0]      wdat = '0;
  logic             we = 1'b0;
  logic [3:0]       sel = '0;
  logic             stb = 1'b0;
  logic             cyc = 1'b0;
  logic [1:0][31:0] rdat;
  logic [1:0]       ack;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rv_wb_sram #(
      .ADDR_BITS   (AB),
      .WAIT_STATES (g + 1),
      .INIT_FILE   ("")
    ) u_dut (
      .i_clk    (clk),
      .i_reset  (rst),
      .i_wb_adr (adr),
      .i_wb_dat (wdat),
      .o_wb_dat (rdat[g]),
      .i_wb_we  (we),
      .i_wb_sel (sel),
      .i_wb_stb (stb),
      .i_wb_cyc (cyc),
      .o_wb_ack (ack[g])
    );
  end

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;

  // Reference model: per instance, a word array with per-byte "known" flags and
  // one pending request with the edge number at which it is due.
  logic [31:0]   m_mem   [2][DEPTH];
  bit   [3:0]    m_known [2][DEPTH];
  bit            m_pend  [2];
  int            m_due   [2];
  bit            m_ack   [2];
  logic [31:0]   m_rd    [2];
  bit            m_rd_ok [2];
  logic [AB-1:0] q_idx   [2];
  logic [31:0]   q_dat   [2];
  logic          q_we    [2];
  logic [3:0]    q_sel   [2];

  int            t_lat   [2];
  logic [31:0]   t_rd    [2];

  task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", name, g, act, exp);
    end
  endtask

  task automatic access(input int g);
    if (q_we[g]) begin
      for (int b = 0; b < 4; b++) begin
        if (q_sel[g][b]) begin
          m_mem[g][q_idx[g]][8*b +: 8] = q_dat[g][8*b +: 8];
          m_known[g][q_idx[g]][b]      = 1'b1;
        end
      end
    end else begin
      m_rd[g]    = m_mem[g][q_idx[g]];
      m_rd_ok[g] = (m_known[g][q_idx[g]] == 4'hF);
    end
  endtask

  // Advance the model across the coming edge e, using the bus values it will sample.
  task automatic step(input int g);
    int e;
    e = ncyc + 1;
    if (m_ack[g]) begin
      m_ack[g] = 1'b0;
    end else if (m_pend[g]) begin
      if (!cyc) begin
        m_pend[g] = 1'b0;
      end else if (e == m_due[g]) begin
        m_pend[g] = 1'b0;
        m_ack[g]  = 1'b1;
        access(g);
      end
    end else if (cyc && stb) begin
      m_pend[g] = 1'b1;
      m_due[g]  = e + g + 1;
      q_idx[g]  = adr[AB+1:2];
      q_dat[g]  = wdat;
      q_we[g]   = we;
      q_sel[g]  = sel;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      ncyc++;
    end
  end

  // Compare process: every cycle, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          m_pend[g]  = 1'b0;
          m_ack[g]   = 1'b0;
          m_rd[g]    = '0;
          m_rd_ok[g] = 1'b1;
        end
        check("ack", g, 32'(ack[g]), 32'(m_ack[g]));
        if (m_rd_ok[g]) check("rdat", g, rdat[g], m_rd[g]);
        if (!rst) step(g);
      end
    end
  end

  task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
    int       t0;
    bit [1:0] seen;
    seen  = '0;
    t_lat = '{-1, -1};
    t_rd  = '{32'h0, 32'h0};
    @(posedge clk); #1;
    adr = a; wdat = d; we = w; sel = s; stb = 1'b1; cyc = 1'b1;
    t0 = ncyc;
    for (int k = 0; k < 12 && seen != 2'b11; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (ack[g] && !seen[g]) begin
          seen[g]  = 1'b1;
          t_lat[g] = ncyc - t0;
          t_rd[g]  = rdat[g];
        end
      end
      @(posedge clk); #1;
      stb = 1'b0;
    end
    cyc = 1'b0;
    for (int g = 0; g < 2; g++) check("ack_seen", g, 32'(seen[g]), 32'd1);
  endtask

  int n_ack;
  int aq0[$];
  int aq1[$];
  int t0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("reset_ack", g, 32'(ack[g]), 32'd0);
      check("reset_rdat", g, rdat[g], 32'h0);
    end
    rst = 1'b0;

    // Write then read back; each ack WAIT_STATES+1 cycles after the request.
    xact(32'h10, 32'hDEADBEEF, 1'b1, 4'hF);
    for (int g = 0; g < 2; g++) check("wr_latency", g, 32'(t_lat[g]), 32'(g + 2));
    xact(32'h10, 32'h0, 1'b0, 4'h0);
    for (int g = 0; g < 2; g++) begin
      check("rd_latency", g, 32'(t_lat[g]), 32'(g + 2));
      check("rd_deadbeef", g, t_rd[g], 32'hDEADBEEF);
    end

    // Byte-merge write.
    xact(32'h20, 32'h11223344, 1'b1, 4'hF);
    xact(32'h20, 32'hAABBCCDD, 1'b1, 4'b0101);
    xact(32'h20, 32'h0, 1'b0, 4'h0);
    for (int g = 0; g < 2; g++) begin
      check("merge_rd", g, t_rd[g], 32'h11BB33DD);
      check("model_pin", g, m_mem[g][8], 32'h11BB33DD);
    end

    // Empty byte-select write is acked and changes nothing.
    xact(32'h20, 32'hFFFFFFFF, 1'b1, 4'h0);
    for (int g = 0; g < 2; g++) check("sel0_latency", g, 32'(t_lat[g]), 32'(g + 2));
    xact(32'h20, 32'h0, 1'b0, 4'h0);
    for (int g = 0; g < 2; g++) check("sel0_rd", g, t_rd[g], 32'h11BB33DD);

    // Held-high stb/cyc: stb high for 13 cycles.
    @(posedge clk); #1;
    adr = 32'h20; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    t0 = ncyc;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack[0]) aq0.push_back(ncyc - t0);
      if (ack[1]) aq1.push_back(ncyc - t0);
      @(posedge clk); #1;
      if (ncyc - t0 >= 13) stb = 1'b0;
    end
    cyc = 1'b0;
    check("burst_cnt", 1, 32'(aq1.size()), 32'd4);
    if (aq1.size() > 0) check("burst_first", 1, 32'(aq1[0]), 32'd3);
    for (int i = 1; i < aq1.size(); i++) check("burst_gap", 1, 32'(aq1[i] - aq1[i-1]), 32'd4);
    check("burst_cnt", 0, 32'(aq0.size()), 32'd5);
    for (int i = 1; i < aq0.size(); i++) check("burst_gap", 0, 32'(aq0[i] - aq0[i-1]), 32'd3);

    // cyc dropped in the first wait cycle of a write.
    xact(32'h30, 32'h12345678, 1'b1, 4'hF);
    @(posedge clk); #1;
    adr = 32'h30; wdat = 32'hFFFFFFFF; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      n_ack += int'(ack[0]) + int'(ack[1]);
    end
    check("abort_ack", 0, 32'(n_ack), 32'd0);
    xact(32'h30, 32'h0, 1'b0, 4'h0);
    for (int g = 0; g < 2; g++) check("abort_rd", g, t_rd[g], 32'h12345678);

    // Reset in the middle of a wait.
    xact(32'h40, 32'hCAFE0001, 1'b1, 4'hF);
    xact(32'h10, 32'h0, 1'b0, 4'h0);
    @(posedge clk); #1;
    adr = 32'h40; wdat = 32'h0BAD0BAD; we = 1'b1; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check("rst_ack", g, 32'(ack[g]), 32'd0);
      check("rst_rdat", g, rdat[g], 32'h0);
    end
    @(posedge clk); #1;
    cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      n_ack += int'(ack[0]) + int'(ack[1]);
    end
    check("rst_noack", 0, 32'(n_ack), 32'd0);
    xact(32'h40, 32'h0, 1'b0, 4'h0);
    for (int g = 0; g < 2; g++) check("rst_keep", g, t_rd[g], 32'hCAFE0001);
    xact(32'h10 + (32'd4 << AB), 32'h0, 1'b0, 4'h0);
    for (int g = 0; g < 2; g++) check("alias_rd", g, t_rd[g], 32'hDEADBEEF);

    // Randomized traffic, including occasional resets, checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst  = ($urandom_range(0, 499) == 0);
      cyc  = ($urandom_range(0, 7) != 0);
      stb  = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom_range(0, 1));
      sel  = 4'($urandom);
      adr  = $urandom;
      wdat = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
